// File: rtl/cipher_result_viewer_pkg.sv
// Shared encodings and helpers for the ciphertext history viewer.
package cipher_result_viewer_pkg;

    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_SCROLL_DIV = 50_000_000;

    // Viewer modes: IDLE until the first capture, then SHOW or SCROLL by auto_scroll.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SCROLL = 2'd2
    } state_e;

    // 16-bit chunk of the 64-bit ciphertext, chunk 0 is the least significant.
    typedef enum logic [1:0] {
        CHUNK_0 = 2'd0,
        CHUNK_1 = 2'd1,
        CHUNK_2 = 2'd2,
        CHUNK_3 = 2'd3
    } chunk_e;

    // Pick one 16-bit chunk out of a 64-bit word.
    function automatic logic [15:0] get_chunk(input logic [63:0] word, input logic [1:0] sel);
        logic [15:0] res;
        case (sel)
            2'd0:    res = word[15:0];
            2'd1:    res = word[31:16];
            2'd2:    res = word[47:32];
            2'd3:    res = word[63:48];
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cipher_result_viewer_edge_detect.sv
// One-flop edge detector: single-cycle pulse on the active edge of sig_i.
// ACTIVE_LOW=0 fires on 0->1, ACTIVE_LOW=1 fires on 1->0 (idle-high buttons).
module cipher_result_viewer_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic pulse_o
);

    logic hist_q;

    // History flop resets to the input's idle level so reset release never fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= ACTIVE_LOW;
        end else begin
            hist_q <= sig_i;
        end
    end

    assign pulse_o = ACTIVE_LOW ? (hist_q & ~sig_i) : (sig_i & ~hist_q);

endmodule

// File: rtl/cipher_result_viewer.sv
// Ciphertext history viewer: captures each ciphertext into a circular buffer and
// drives a 16-bit chunk of the selected entry to the hex display, either under
// manual control or by timed auto-scroll.
module cipher_result_viewer
    import cipher_result_viewer_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int SCROLL_DIV = DEFAULT_SCROLL_DIV,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   msg_in,
    input  logic          msg_valid,
    input  logic          next_entry,
    input  logic [1:0]    select_disp,
    input  logic          auto_scroll,
    output logic [15:0]   disp,
    output logic [AW-1:0] entry_idx,
    output logic [AW:0]   count,
    output logic          buf_full,
    output logic          overflow
);

    localparam int            CW   = $clog2(SCROLL_DIV);
    localparam logic [CW-1:0] TERM = CW'(SCROLL_DIV - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    logic [63:0]   mem [0:DEPTH-1];

    state_e        state_q,     state_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW:0]   count_q,     count_d;
    logic [AW-1:0] entry_idx_q, entry_idx_d;
    chunk_e        chunk_q,     chunk_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          overflow_q,  overflow_d;
    logic          buf_full_q,  buf_full_d;
    logic [15:0]   disp_q,      disp_d;

    logic          cap_s;
    logic          btn_s;
    logic [AW-1:0] oldest_s;
    logic [AW-1:0] newest_s;
    logic [AW-1:0] adv_idx_s;
    logic [1:0]    sel_s;

    cipher_result_viewer_edge_detect #(.ACTIVE_LOW(1'b0)) u_valid_edge (
        .clk_i   (clk),
        .rst_ni  (rst),
        .sig_i   (msg_valid),
        .pulse_o (cap_s)
    );

    cipher_result_viewer_edge_detect #(.ACTIVE_LOW(1'b1)) u_btn_edge (
        .clk_i   (clk),
        .rst_ni  (rst),
        .sig_i   (next_entry),
        .pulse_o (btn_s)
    );

    // Next-older entry, wrapping from the oldest valid entry back to the newest.
    always_comb begin
        oldest_s = wr_ptr_q - count_q[AW-1:0];
        newest_s = wr_ptr_q - AW'(1);
        if (entry_idx_q == oldest_s) begin
            adv_idx_s = newest_s;
        end else begin
            adv_idx_s = entry_idx_q - AW'(1);
        end
    end

    // Mode selection plus capture, entry navigation and scroll timing.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        entry_idx_d = entry_idx_q;
        chunk_d     = chunk_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (cap_s) begin
                    state_d = auto_scroll ? ST_SCROLL : ST_SHOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW, ST_SCROLL: begin
                state_d = auto_scroll ? ST_SCROLL : ST_SHOW;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cap_s) begin
            // A capture beats a same-cycle button edge or scroll terminal count.
            wr_ptr_d    = wr_ptr_q + AW'(1);
            entry_idx_d = wr_ptr_q;
            chunk_d     = CHUNK_0;
            cnt_d       = '0;
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (AW + 1)'(1);
            end
        end else if ((state_q != ST_IDLE) && btn_s) begin
            entry_idx_d = adv_idx_s;
            chunk_d     = CHUNK_0;
            cnt_d       = '0;
        end else if ((state_q == ST_SCROLL) && (state_d == ST_SCROLL)) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
                if (chunk_q == CHUNK_3) begin
                    chunk_d     = CHUNK_0;
                    entry_idx_d = adv_idx_s;
                end else begin
                    chunk_d = chunk_e'(chunk_q + 2'd1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // Outside a running scroll the timer and chunk sit at zero, so
            // entering SCROLL always starts from chunk 0 with a fresh count.
            cnt_d   = '0;
            chunk_d = CHUNK_0;
        end
    end

    assign buf_full_d = (count_d == FULL);

    // Display mux: blank while idle, scroll chunk in SCROLL, user chunk in SHOW.
    always_comb begin
        if (state_q == ST_SCROLL) begin
            sel_s = chunk_q;
        end else begin
            sel_s = select_disp;
        end
        if (state_q == ST_IDLE) begin
            disp_d = 16'h0000;
        end else begin
            disp_d = get_chunk(mem[entry_idx_q], sel_s);
        end
    end

    // History buffer write port; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (cap_s) begin
            mem[wr_ptr_q] <= msg_in;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            entry_idx_q <= '0;
            chunk_q     <= CHUNK_0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            disp_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            entry_idx_q <= entry_idx_d;
            chunk_q     <= chunk_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            buf_full_q  <= buf_full_d;
            disp_q      <= disp_d;
        end
    end

    assign disp      = disp_q;
    assign entry_idx = entry_idx_q;
    assign count     = count_q;
    assign buf_full  = buf_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cipher_result_viewer.sv
// Self-checking bench for cipher_result_viewer with a queue-based reference model.
module tb_cipher_result_viewer;

    localparam int DEPTH      = 4;
    localparam int SCROLL_DIV = 4;

    logic        clk;
    logic        rst;
    logic [63:0] msg_in;
    logic        msg_valid;
    logic        next_entry;
    logic [1:0]  select_disp;
    logic        auto_scroll;
    logic [15:0] disp;
    logic [1:0]  entry_idx;
    logic [2:0]  count;
    logic        buf_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [63:0] data [0:4];

    cipher_result_viewer #(.DEPTH(DEPTH), .SCROLL_DIV(SCROLL_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .msg_in      (msg_in),
        .msg_valid   (msg_valid),
        .next_entry  (next_entry),
        .select_disp (select_disp),
        .auto_scroll (auto_scroll),
        .disp        (disp),
        .entry_idx   (entry_idx),
        .count       (count),
        .buf_full    (buf_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: history kept as a queue (newest at back), view kept as an age.
    logic [63:0] m_q [$];
    int          m_ncap  = 0;
    int          m_age   = 0;
    int          m_mode  = 0;
    int          m_tick  = 0;
    int          m_chunk = 0;
    logic        m_ovf   = 1'b0;
    logic        m_pv    = 1'b0;
    logic        m_pb    = 1'b1;
    logic [15:0] m_disp  = 16'h0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_ncap = 0; m_age = 0; m_mode = 0; m_tick = 0; m_chunk = 0;
                m_ovf = 1'b0; m_pv = 1'b0; m_pb = 1'b1; m_disp = 16'h0;
            end else begin
                logic        cap, btn;
                logic [63:0] w;
                int          c, nm;
                cap  = msg_valid && !m_pv;
                btn  = !next_entry && m_pb;
                m_pv = msg_valid;
                m_pb = next_entry;
                if (m_mode == 0) begin
                    m_disp = 16'h0;
                end else begin
                    w = m_q[m_q.size() - 1 - m_age];
                    c = (m_mode == 2) ? m_chunk : int'(select_disp);
                    m_disp = w[c*16 +: 16];
                end
                nm = (m_mode == 0 && !cap) ? 0 : (auto_scroll ? 2 : 1);
                if (cap) begin
                    m_q.push_back(msg_in);
                    if (m_q.size() > DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ncap++;
                    m_age = 0; m_chunk = 0; m_tick = 0;
                end else if (m_mode != 0 && btn) begin
                    m_age = (m_age + 1) % m_q.size();
                    m_chunk = 0; m_tick = 0;
                end else if (m_mode == 2 && nm == 2) begin
                    m_tick++;
                    if (m_tick == SCROLL_DIV) begin
                        m_tick = 0;
                        m_chunk++;
                        if (m_chunk == 4) begin
                            m_chunk = 0;
                            m_age = (m_age + 1) % m_q.size();
                        end
                    end
                end else begin
                    m_tick = 0; m_chunk = 0;
                end
                m_mode = nm;
            end
        end
    end

    // Expected {disp, entry_idx, count, buf_full, overflow} from the model.
    function automatic logic [22:0] exp_vec();
        logic [1:0] idx;
        logic [2:0] cnt;
        idx = (m_ncap == 0) ? 2'd0 : 2'((m_ncap - 1 - m_age) % DEPTH);
        cnt = 3'(m_q.size());
        return {m_disp, idx, cnt, (m_q.size() == DEPTH), m_ovf};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; msg_valid = 1'b0; next_entry = 1'b1;
        auto_scroll = 1'b0; select_disp = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic capture(input logic [63:0] d);
        msg_in = d; msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        tick();
    endtask

    task automatic press();
        next_entry = 1'b0;
        tick();
        next_entry = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({disp, entry_idx, count, buf_full, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {disp, entry_idx, count, buf_full, overflow});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        next_entry = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({disp, entry_idx, count, buf_full, overflow} !== 23'd0) begin
                errors++;
                $display("FAIL idle_button: got %h want 0", {disp, entry_idx, count, buf_full, overflow});
            end
        end
        next_entry = 1'b1;
        tick();
    endtask

    task automatic test_capture();
        select_disp = 2'd0;
        msg_in = 64'h0123_4567_89AB_CDEF;
        msg_valid = 1'b1;
        tick();
        checks++;
        if (disp !== 16'h0000 || count !== 3'd1) begin
            errors++;
            $display("FAIL capture_edge1: disp %h count %0d want 0000 1", disp, count);
        end
        tick();
        checks++;
        if (disp !== 16'hCDEF) begin
            errors++;
            $display("FAIL capture_latency: got %h want CDEF", disp);
        end
        select_disp = 2'd3;
        tick();
        checks++;
        if (disp !== 16'h0123) begin
            errors++;
            $display("FAIL select3: got %h want 0123", disp);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({disp, entry_idx, count, buf_full, overflow} !== exp_vec() || count !== 3'd1) begin
                errors++;
                $display("FAIL hold_valid cyc %0d: got %h want %h", i, {disp, entry_idx, count, buf_full, overflow}, exp_vec());
            end
        end
        msg_valid = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [1:0] slots [0:2];
        slots[0] = 2'd1; slots[1] = 2'd0; slots[2] = 2'd2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            data[i] = {$urandom, $urandom};
            capture(data[i]);
        end
        checks++;
        if (entry_idx !== 2'd2 || disp !== data[2][15:0]) begin
            errors++;
            $display("FAIL wrap_newest: idx %0d disp %h want 2 %h", entry_idx, disp, data[2][15:0]);
        end
        for (int p = 0; p < 3; p++) begin
            press();
            checks++;
            if (entry_idx !== slots[p] || disp !== data[slots[p]][15:0] ||
                {disp, entry_idx, count, buf_full, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_press%0d: idx %0d disp %h want %0d %h", p, entry_idx, disp, slots[p], data[slots[p]][15:0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] w;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            data[i] = {$urandom, $urandom};
            capture(data[i]);
        end
        checks++;
        if (count !== 3'd4 || buf_full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flags: count %0d full %b ovf %b want 4 1 1", count, buf_full, overflow);
        end
        for (int k = 0; k < 5; k++) begin
            select_disp = 2'($urandom_range(3));
            tick();
            w = data[(k == 4) ? 4 : 4 - k] >> (16 * int'(select_disp));
            checks++;
            if (disp !== w[15:0] || {disp, entry_idx, count, buf_full, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_view%0d: got %h want %h", k, disp, w[15:0]);
            end
            press();
        end
    endtask

    task automatic test_scroll();
        logic [15:0] want;
        do_reset();
        auto_scroll = 1'b1;
        data[0] = {$urandom, $urandom};
        data[1] = {$urandom, $urandom};
        capture(data[0]);
        capture(data[1]);
        for (int j = 2; j <= 22; j++) begin
            tick();
            if (j <= 16) want = data[1][16*((j-1)/4) +: 16];
            else if (j <= 20) want = data[0][15:0];
            else want = data[0][31:16];
            checks++;
            if (disp !== want || {disp, entry_idx, count, buf_full, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL scroll_step%0d: got %h want %h", j, disp, want);
            end
        end
        press();
        for (int j = 1; j <= 5; j++) begin
            want = (j <= 4) ? data[1][15:0] : data[1][31:16];
            checks++;
            if (disp !== want || entry_idx !== 2'd1 || {disp, entry_idx, count, buf_full, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL scroll_press%0d: disp %h idx %0d want %h 1", j, disp, entry_idx, want);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 3; i++) data[i] = {$urandom, $urandom};
        capture(data[0]);
        capture(data[1]);
        press();
        msg_in = data[2]; msg_valid = 1'b1; next_entry = 1'b0;
        tick();
        checks++;
        if (entry_idx !== 2'd2 || count !== 3'd3) begin
            errors++;
            $display("FAIL cap_vs_btn: idx %0d count %0d want 2 3", entry_idx, count);
        end
        msg_valid = 1'b0; next_entry = 1'b1;
        tick();
        tick();
        checks++;
        if (entry_idx !== 2'd2 || disp !== data[2][15:0] || {disp, entry_idx, count, buf_full, overflow} !== exp_vec()) begin
            errors++;
            $display("FAIL cap_vs_btn_view: idx %0d disp %h want 2 %h", entry_idx, disp, data[2][15:0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            msg_in      = {$urandom, $urandom};
            msg_valid   = ($urandom_range(4) == 0);
            next_entry  = ($urandom_range(3) != 0);
            select_disp = 2'($urandom_range(3));
            if ($urandom_range(40) == 0) auto_scroll = ~auto_scroll;
            tick();
            checks++;
            if ({disp, entry_idx, count, buf_full, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, {disp, entry_idx, count, buf_full, overflow}, exp_vec());
            end
        end
        msg_valid = 1'b0; next_entry = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        auto_scroll = 1'b1;
        capture({$urandom, $urandom});
        repeat (6) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({disp, entry_idx, count, buf_full, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", {disp, entry_idx, count, buf_full, overflow});
        end
        @(negedge clk);
        rst = 1'b1;
        auto_scroll = 1'b0;
        tick();
        checks++;
        if ({disp, entry_idx, count, buf_full, overflow} !== exp_vec() || count !== 3'd0) begin
            errors++;
            $display("FAIL after_reset: got %h want %h", {disp, entry_idx, count, buf_full, overflow}, exp_vec());
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; msg_in = 64'h0; msg_valid = 1'b0;
        next_entry = 1'b1; select_disp = 2'd0; auto_scroll = 1'b0;
        #1 rst = 1'b0;
        test_reset();
        test_capture();
        test_wrap();
        test_overflow();
        test_scroll();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
